// File: rtl/fadd_arb.sv
// rtl/fadd_arb.sv - two-port round-robin arbiter in front of a shared pipelined FP adder
module fadd_arb #(
    parameter int N     = 32,
    parameter int TAGW  = 4,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [N-1:0]    req0_a,
    input  logic [N-1:0]    req0_b,
    input  logic [2:0]      req0_frm,
    input  logic [TAGW-1:0] req0_tag,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [N-1:0]    req1_a,
    input  logic [N-1:0]    req1_b,
    input  logic [2:0]      req1_frm,
    input  logic [TAGW-1:0] req1_tag,
    input  logic [2:0]      csr_frm,
    output logic            fu_valid,
    output logic [N-1:0]    fu_a,
    output logic [N-1:0]    fu_b,
    output logic [2:0]      fu_frm,
    input  logic [N-1:0]    fu_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [N-1:0]    res_data,
    output logic [TAGW-1:0] res_tag,
    output logic            res_src,
    output logic            res_ill
);
    localparam int AW = $clog2(DEPTH);

    logic            rr_q, rr_d;
    logic [LAT-1:0]  pv_q, pv_d;
    logic [TAGW-1:0] pt_q [LAT];
    logic [TAGW-1:0] pt_d [LAT];
    logic [LAT-1:0]  ps_q, ps_d;
    logic [LAT-1:0]  pi_q, pi_d;
    logic [N-1:0]    md_q [DEPTH];
    logic [N-1:0]    md_d [DEPTH];
    logic [TAGW-1:0] mt_q [DEPTH];
    logic [TAGW-1:0] mt_d [DEPTH];
    logic [DEPTH-1:0] ms_q, ms_d;
    logic [DEPTH-1:0] mi_q, mi_d;
    logic [AW:0]     wp_q, wp_d;
    logic [AW:0]     rp_q, rp_d;

    int              inflight;
    logic [AW:0]     fifo_count;
    logic            credit_ok;
    logic            grant;
    logic            win;
    logic [2:0]      sel_frm;
    logic [2:0]      rslv_frm;
    logic            launch_ill;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    // Credits: every launched op owns a FIFO slot until it is popped
    always_comb begin
        inflight = 0;
        for (int i = 0; i < LAT; i++) begin
            if (pv_q[i]) inflight = inflight + 1;
        end
        fifo_count = wp_q - rp_q;
        credit_ok  = (inflight + int'(fifo_count)) < DEPTH;
    end

    // Arbitration, rounding-mode resolution and operand launch
    always_comb begin
        win        = (req0_valid && req1_valid) ? rr_q : req1_valid;
        grant      = rst_n && credit_ok && (req0_valid || req1_valid);
        req0_ready = grant && !win;
        req1_ready = grant && win;
        sel_frm    = win ? req1_frm : req0_frm;
        rslv_frm   = (sel_frm == 3'b111) ? csr_frm : sel_frm;
        launch_ill = rslv_frm[2] && (rslv_frm[1] || rslv_frm[0]);
        fu_valid   = grant;
        fu_a       = '0;
        fu_b       = '0;
        fu_frm     = '0;
        if (grant) begin
            fu_a   = win ? req1_a : req0_a;
            fu_b   = win ? req1_b : req0_b;
            fu_frm = rslv_frm;
        end
        rr_d = grant ? ~win : rr_q;
    end

    // In-flight tracking pipe and in-order result FIFO
    always_comb begin
        pv_d    = pv_q;
        pt_d    = pt_q;
        ps_d    = ps_q;
        pi_d    = pi_q;
        pv_d[0] = grant;
        pt_d[0] = win ? req1_tag : req0_tag;
        ps_d[0] = win;
        pi_d[0] = launch_ill;
        for (int i = 1; i < LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
            ps_d[i] = ps_q[i-1];
            pi_d[i] = pi_q[i-1];
        end
        fifo_empty = (wp_q == rp_q);
        push       = pv_q[LAT-1];
        pop        = !fifo_empty && res_ready;
        md_d       = md_q;
        mt_d       = mt_q;
        ms_d       = ms_q;
        mi_d       = mi_q;
        if (push) begin
            md_d[wp_q[AW-1:0]] = fu_out;
            mt_d[wp_q[AW-1:0]] = pt_q[LAT-1];
            ms_d[wp_q[AW-1:0]] = ps_q[LAT-1];
            mi_d[wp_q[AW-1:0]] = pi_q[LAT-1];
        end
        wp_d      = wp_q + (AW+1)'(push);
        rp_d      = rp_q + (AW+1)'(pop);
        res_valid = !fifo_empty;
        res_data  = md_q[rp_q[AW-1:0]];
        res_tag   = mt_q[rp_q[AW-1:0]];
        res_src   = ms_q[rp_q[AW-1:0]];
        res_ill   = mi_q[rp_q[AW-1:0]];
    end

    // State registers; reset drops everything in flight and buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
            pv_q <= '0;
            ps_q <= '0;
            pi_q <= '0;
            for (int i = 0; i < LAT; i++) pt_q[i] <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                md_q[i] <= '0;
                mt_q[i] <= '0;
            end
            ms_q <= '0;
            mi_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            rr_q <= rr_d;
            pv_q <= pv_d;
            pt_q <= pt_d;
            ps_q <= ps_d;
            pi_q <= pi_d;
            md_q <= md_d;
            mt_q <= mt_d;
            ms_q <= ms_d;
            mi_q <= mi_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
endmodule

// File: tb/tb_fadd_arb.sv
// tb/tb_fadd_arb.sv - scoreboard bench for fadd_arb
module tb_fadd_arb;
    localparam int N = 32, TAGW = 4, LAT = 2, DEPTH = 4;

    logic clk = 0, rst_n = 0;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [N-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_frm = 0, req1_frm = 0, csr_frm = 0;
    logic [TAGW-1:0] req0_tag = 0, req1_tag = 0;
    logic fu_valid;
    logic [N-1:0] fu_a, fu_b, fu_out;
    logic [2:0] fu_frm;
    logic res_valid, res_ready = 0, res_src, res_ill;
    logic [N-1:0] res_data;
    logic [TAGW-1:0] res_tag;

    fadd_arb #(.N(N), .TAGW(TAGW), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_frm(req0_frm), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_frm(req1_frm), .req1_tag(req1_tag),
        .csr_frm(csr_frm), .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b), .fu_frm(fu_frm),
        .fu_out(fu_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_src(res_src), .res_ill(res_ill)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    data;
        logic [TAGW-1:0] tag;
        logic            src;
        logic            ill;
    } exp_t;

    exp_t sb[$];
    logic win_log[$];
    logic ill_log[$];
    int   n_checks = 0, n_pass = 0, grants = 0;
    logic m_rr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [N-1:0] fadd_model(input logic [N-1:0] a, input logic [N-1:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return a + {b[15:0], b[31:16]};
    endfunction

    function automatic logic [2:0] resolve(input logic [2:0] frm, input logic [2:0] csr);
        return (frm == 3'b111) ? csr : frm;
    endfunction

    // Behavioural adder: fixed latency, garbage when nothing was launched
    logic [N-1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= fu_valid ? fadd_model(fu_a, fu_b) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign fu_out = apipe[LAT-1];

    // Monitor: predicts grants from its own credit/rr model, scoreboards results
    always @(negedge clk) begin : mon
        exp_t e;
        logic w, exp_grant;
        logic [2:0] rf;
        if (!rst_n) begin
            sb.delete();
            m_rr = 0;
            if (req0_valid || req1_valid)
                check("rst_ready", {61'd0, req0_ready, req1_ready, fu_valid}, 0);
        end else begin
            if (req0_valid || req1_valid) begin
                exp_grant = sb.size() < DEPTH;
                check("grant", req0_ready | req1_ready, exp_grant);
                if (exp_grant) begin
                    w = (req0_valid && req1_valid) ? m_rr : req1_valid;
                    check("winner", {62'd0, req1_ready, req0_ready}, w ? 64'd2 : 64'd1);
                    check("fu_valid", fu_valid, 1);
                    check("fu_a", fu_a, w ? req1_a : req0_a);
                    check("fu_b", fu_b, w ? req1_b : req0_b);
                    rf = resolve(w ? req1_frm : req0_frm, csr_frm);
                    check("fu_frm", fu_frm, rf);
                    e.data = fadd_model(w ? req1_a : req0_a, w ? req1_b : req0_b);
                    e.tag  = w ? req1_tag : req0_tag;
                    e.src  = w;
                    e.ill  = (rf >= 3'd5);
                    sb.push_back(e);
                    win_log.push_back(w);
                    m_rr = !w;
                    grants++;
                end
            end
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", {res_data, res_tag, res_src, res_ill}, e);
                    ill_log.push_back(res_ill);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 0;
        req1_valid = 0;
        res_ready  = 1;
        for (int i = 0; i < 40 && (sb.size() != 0 || res_valid); i++) step();
        check("drain", sb.size(), 0);
        check("drain_res_valid", res_valid, 0);
    endtask

    initial begin
        // Reset state, with a request present that must not be accepted
        req0_valid = 1;
        step();
        step();
        check("rst_outputs", {60'd0, req0_ready, req1_ready, fu_valid, res_valid}, 0);
        check("rst_fu_a", fu_a, 0);
        check("rst_fu_frm", fu_frm, 0);
        req0_valid = 0;
        rst_n = 1;
        step();

        // Both ports every cycle: strict alternation, one op per cycle
        res_ready = 1;
        win_log.delete();
        grants = 0;
        req0_valid = 1;
        req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_tag = 4'(i);
            req1_a = $urandom; req1_b = $urandom; req1_tag = 4'(i + 8);
            step();
        end
        req0_valid = 0;
        req1_valid = 0;
        check("alt_throughput", grants, 8);
        for (int i = 0; i < 4; i++) check("alt_order", win_log[i], 64'(i % 2));
        drain();

        // Single op latency on port 0
        req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_frm = 0; req0_tag = 3;
        req0_valid = 1;
        #1;
        check("lat_fu_valid", fu_valid, 1);
        check("lat_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        for (int k = 1; k <= LAT + 1; k++) begin
            check("lat_res_valid", res_valid, 64'(k == LAT + 1));
            if (k < LAT + 1) step();
        end
        check("lat_res_data", res_data, 32'h4040_0000);
        check("lat_res_tag", {res_tag, res_src, res_ill}, {4'd3, 1'b0, 1'b0});
        drain();

        // Backpressure: credits cap acceptance at DEPTH, a pop frees one next cycle
        res_ready = 0;
        grants = 0;
        req1_valid = 1;
        for (int i = 0; i < 8; i++) begin
            req1_a = $urandom; req1_b = $urandom; req1_tag = 4'(i);
            step();
        end
        check("bp_grants", grants, DEPTH);
        check("bp_ready_full", req1_ready, 0);
        res_ready = 1;
        #1;
        check("bp_same_cycle", req1_ready, 0);
        step();
        res_ready = 0;
        check("bp_next_cycle", req1_ready, 1);
        step();
        check("bp_full_again", req1_ready, 0);
        check("bp_grants2", grants, DEPTH + 1);
        drain();

        // Rounding-mode resolution and illegal modes keep their slot in order
        ill_log.delete();
        req0_valid = 1;
        req0_frm = 3'b111; csr_frm = 3'b010;
        #1;
        check("frm_dyn", fu_frm, 3'b010);
        step();
        req0_frm = 3'b111; csr_frm = 3'b101;
        step();
        req0_frm = 3'b110; csr_frm = 3'b000;
        step();
        drain();
        check("ill_count", ill_log.size(), 3);
        if (ill_log.size() == 3) check("ill_seq", {ill_log[0], ill_log[1], ill_log[2]}, 3'b011);

        // Reset mid-operation: one buffered, two in flight
        res_ready = 0;
        req0_frm = 0;
        req0_valid = 1;
        step();
        req0_valid = 0;
        step();
        step();
        req0_valid = 1;
        step();
        step();
        req0_valid = 0;
        rst_n = 0;
        #1;
        check("rst_async_res_valid", res_valid, 0);
        step();
        rst_n = 1;
        res_ready = 1;
        for (int i = 0; i < 6; i++) begin
            check("rst_no_stale", res_valid, 0);
            step();
        end
        req0_valid = 1;
        req1_valid = 1;
        #1;
        check("rst_rr_zero", {62'd0, req1_ready, req0_ready}, 1);
        step();
        drain();

        // Random traffic with random backpressure: wrap, full push+pop
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(9) < 7);
            req1_valid = ($urandom_range(9) < 7);
            res_ready  = ($urandom_range(9) < 6);
            req0_a = $urandom; req0_b = $urandom; req0_frm = 3'($urandom); req0_tag = 4'($urandom);
            req1_a = $urandom; req1_b = $urandom; req1_frm = 3'($urandom); req1_tag = 4'($urandom);
            csr_frm = 3'($urandom);
            step();
            check("no_overflow", sb.size() <= DEPTH, 1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
